// File: rtl/ex_stage_module_pkg.sv
// Shared widths, ALU opcodes, shift-type and forwarding-select codes for the EX stage.
package ex_stage_module_pkg;
    localparam int ADDRESS_LEN     = 32;
    localparam int REGISTER_LEN    = 32;
    localparam int REG_ADDRESS_LEN = 4;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Code 11 is unused and falls back to the register-file value.
    function automatic logic [REGISTER_LEN-1:0] fwd_mux(
        input logic [1:0]              sel,
        input logic [REGISTER_LEN-1:0] rf,
        input logic [REGISTER_LEN-1:0] mem,
        input logic [REGISTER_LEN-1:0] wb
    );
        case (sel)
            FWD_MEM: fwd_mux = mem;
            FWD_WB:  fwd_mux = wb;
            default: fwd_mux = rf;
        endcase
    endfunction

    function automatic logic [REGISTER_LEN-1:0] ror32(
        input logic [REGISTER_LEN-1:0] x,
        input logic [4:0]              amt
    );
        ror32 = (x >> amt) | (x << (6'd32 - {1'b0, amt}));
    endfunction
endpackage

// File: rtl/ex_stage_module_val2_generator.sv
// Second-operand generator: rotated immediate, memory offset, or shifted register.
module val2_generator
    import ex_stage_module_pkg::*;
(
    input  logic [REGISTER_LEN-1:0] val_b_i,
    input  logic [11:0]             shift_operand_i,
    input  logic                    immediate_i,
    input  logic                    mem_en_i,
    output logic [REGISTER_LEN-1:0] val2_o
);
    logic [4:0]              amt;
    logic [REGISTER_LEN-1:0] imm_ext;

    assign amt     = shift_operand_i[11:7];
    assign imm_ext = {24'b0, shift_operand_i[7:0]};

    always_comb begin
        val2_o = val_b_i;
        if (immediate_i) begin
            val2_o = ror32(imm_ext, {shift_operand_i[11:8], 1'b0});
        end else if (mem_en_i) begin
            val2_o = {20'b0, shift_operand_i};
        end else begin
            case (shift_operand_i[6:5])
                SHIFT_LSL: val2_o = val_b_i << amt;
                SHIFT_LSR: val2_o = val_b_i >> amt;
                SHIFT_ASR: val2_o = $signed(val_b_i) >>> amt;
                default:   val2_o = ror32(val_b_i, amt);
            endcase
        end
    end
endmodule

// File: rtl/ex_stage_module.sv
// Execute stage: forwarding, ALU, NZCV register, branch target and EX/MEM register.
module ex_stage_module
    import ex_stage_module_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic [ADDRESS_LEN-1:0]     PC_in,
    input  logic [3:0]                 execute_command_in,
    input  logic                       mem_read_en_in,
    input  logic                       mem_write_en_in,
    input  logic                       wb_enable_in,
    input  logic                       immediate_in,
    input  logic                       branch_taken_in,
    input  logic                       status_write_enable_in,
    input  logic [REGISTER_LEN-1:0]    reg_file_in1,
    input  logic [REGISTER_LEN-1:0]    reg_file_in2,
    input  logic [REG_ADDRESS_LEN-1:0] dest_reg_in,
    input  logic [23:0]                signed_immediate_in,
    input  logic [11:0]                shift_operand_in,
    input  logic [1:0]                 fwd_sel_a,
    input  logic [1:0]                 fwd_sel_b,
    input  logic [REGISTER_LEN-1:0]    mem_fwd_data,
    input  logic [REGISTER_LEN-1:0]    wb_fwd_data,
    output logic                       branch_taken_out,
    output logic [ADDRESS_LEN-1:0]     branch_address_out,
    output logic [3:0]                 status_reg_out,
    output logic [REGISTER_LEN-1:0]    alu_result_out,
    output logic [REGISTER_LEN-1:0]    store_value_out,
    output logic [REG_ADDRESS_LEN-1:0] dest_reg_out,
    output logic                       wb_enable_out,
    output logic                       mem_read_en_out,
    output logic                       mem_write_en_out
);
    logic [REGISTER_LEN-1:0] op_a, op_b, val2, addend, res_d;
    logic [REGISTER_LEN:0]   sum;
    logic                    carry_in, is_arith, op_valid;
    logic [3:0]              status_d, status_q;

    assign op_a = fwd_mux(fwd_sel_a, reg_file_in1, mem_fwd_data, wb_fwd_data);
    assign op_b = fwd_mux(fwd_sel_b, reg_file_in2, mem_fwd_data, wb_fwd_data);

    val2_generator u_val2 (
        .val_b_i         (op_b),
        .shift_operand_i (shift_operand_in),
        .immediate_i     (immediate_in),
        .mem_en_i        (mem_read_en_in | mem_write_en_in),
        .val2_o          (val2)
    );

    assign branch_taken_out   = branch_taken_in;
    assign branch_address_out = PC_in + {{6{signed_immediate_in[23]}}, signed_immediate_in, 2'b00};

    // Subtraction is A + ~Val2 + carry_in so C comes out as not-borrow.
    always_comb begin
        addend   = val2;
        carry_in = 1'b0;
        case (execute_command_in)
            EXE_ADC: carry_in = status_q[1];
            EXE_SUB: begin addend = ~val2; carry_in = 1'b1; end
            EXE_SBC: begin addend = ~val2; carry_in = status_q[1]; end
            default: ;
        endcase
    end

    assign sum      = {1'b0, op_a} + {1'b0, addend} + {{REGISTER_LEN{1'b0}}, carry_in};
    assign is_arith = execute_command_in inside {EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC};

    always_comb begin
        res_d    = '0;
        op_valid = 1'b1;
        case (execute_command_in)
            EXE_MOV: res_d = val2;
            EXE_MVN: res_d = ~val2;
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: res_d = sum[REGISTER_LEN-1:0];
            EXE_AND: res_d = op_a & val2;
            EXE_ORR: res_d = op_a | val2;
            EXE_EOR: res_d = op_a ^ val2;
            default: op_valid = 1'b0;
        endcase
    end

    always_comb begin
        status_d    = status_q;
        status_d[3] = res_d[REGISTER_LEN-1];
        status_d[2] = (res_d == '0);
        if (is_arith) begin
            status_d[1] = sum[REGISTER_LEN];
            status_d[0] = (op_a[REGISTER_LEN-1] == addend[REGISTER_LEN-1]) &&
                          (res_d[REGISTER_LEN-1] != op_a[REGISTER_LEN-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q         <= '0;
            alu_result_out   <= '0;
            store_value_out  <= '0;
            dest_reg_out     <= '0;
            wb_enable_out    <= 1'b0;
            mem_read_en_out  <= 1'b0;
            mem_write_en_out <= 1'b0;
        end else if (!freeze) begin
            if (status_write_enable_in && op_valid) status_q <= status_d;
            alu_result_out   <= res_d;
            store_value_out  <= op_b;
            dest_reg_out     <= dest_reg_in;
            wb_enable_out    <= wb_enable_in;
            mem_read_en_out  <= mem_read_en_in;
            mem_write_en_out <= mem_write_en_in;
        end
    end

    assign status_reg_out = status_q;
endmodule

// File: tb/tb_ex_stage_module.sv
// Directed bench for ex_stage_module with hand-computed expectations.
module tb_ex_stage_module;
    logic        clk = 1'b0;
    logic        rst, freeze;
    logic [31:0] PC_in;
    logic [3:0]  execute_command_in;
    logic        mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in;
    logic        branch_taken_in, status_write_enable_in;
    logic [31:0] reg_file_in1, reg_file_in2;
    logic [3:0]  dest_reg_in;
    logic [23:0] signed_immediate_in;
    logic [11:0] shift_operand_in;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        branch_taken_out;
    logic [31:0] branch_address_out;
    logic [3:0]  status_reg_out;
    logic [31:0] alu_result_out, store_value_out;
    logic [3:0]  dest_reg_out;
    logic        wb_enable_out, mem_read_en_out, mem_write_en_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage_module dut (
        .clk(clk), .rst(rst), .freeze(freeze), .PC_in(PC_in),
        .execute_command_in(execute_command_in),
        .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
        .wb_enable_in(wb_enable_in), .immediate_in(immediate_in),
        .branch_taken_in(branch_taken_in), .status_write_enable_in(status_write_enable_in),
        .reg_file_in1(reg_file_in1), .reg_file_in2(reg_file_in2),
        .dest_reg_in(dest_reg_in), .signed_immediate_in(signed_immediate_in),
        .shift_operand_in(shift_operand_in), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .branch_taken_out(branch_taken_out), .branch_address_out(branch_address_out),
        .status_reg_out(status_reg_out), .alu_result_out(alu_result_out),
        .store_value_out(store_value_out), .dest_reg_out(dest_reg_out),
        .wb_enable_out(wb_enable_out), .mem_read_en_out(mem_read_en_out),
        .mem_write_en_out(mem_write_en_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one ALU operation; control bits other than those given are cleared.
    task automatic op(input logic [3:0] cmd, input logic imm, input logic [11:0] so,
                      input logic [31:0] a, input logic [31:0] b, input logic swe);
        execute_command_in     = cmd;
        immediate_in           = imm;
        shift_operand_in       = so;
        reg_file_in1           = a;
        reg_file_in2           = b;
        status_write_enable_in = swe;
        mem_read_en_in         = 1'b0;
        mem_write_en_in        = 1'b0;
        fwd_sel_a              = 2'b00;
        fwd_sel_b              = 2'b00;
    endtask

    initial begin
        rst = 1'b1; freeze = $urandom_range(0, 1);
        PC_in = $urandom; execute_command_in = 4'b0010;
        mem_read_en_in = 1'b1; mem_write_en_in = 1'b1; wb_enable_in = 1'b1;
        immediate_in = $urandom_range(0, 1); branch_taken_in = 1'b0;
        status_write_enable_in = 1'b1;
        reg_file_in1 = $urandom; reg_file_in2 = $urandom; dest_reg_in = 4'hF;
        signed_immediate_in = 24'h0; shift_operand_in = $urandom;
        fwd_sel_a = 2'b00; fwd_sel_b = 2'b00; mem_fwd_data = $urandom; wb_fwd_data = $urandom;
        step(); step();
        check("rst_alu", alu_result_out, 32'h0);
        check("rst_store", store_value_out, 32'h0);
        check("rst_status", {28'h0, status_reg_out}, 32'h0);
        check("rst_dest", {28'h0, dest_reg_out}, 32'h0);
        check("rst_ctrl", {29'h0, wb_enable_out, mem_read_en_out, mem_write_en_out}, 32'h0);

        rst = 1'b0; freeze = 1'b0;
        op(4'b0010, 1'b1, 12'h001, 32'h7FFFFFFF, 32'h000000AA, 1'b1);
        wb_enable_in = 1'b1; dest_reg_in = 4'h3;
        step();
        check("add_ovf_res", alu_result_out, 32'h80000000);
        check("add_ovf_nzcv", {28'h0, status_reg_out}, 32'h9);
        check("add_dest", {28'h0, dest_reg_out}, 32'h3);
        check("add_store", store_value_out, 32'h000000AA);
        check("add_ctrl", {29'h0, wb_enable_out, mem_read_en_out, mem_write_en_out}, 32'h4);

        op(4'b0100, 1'b1, 12'h005, 32'h5, 32'h0, 1'b1);
        step();
        check("cmp_res", alu_result_out, 32'h0);
        check("cmp_nzcv", {28'h0, status_reg_out}, 32'h6);

        op(4'b0011, 1'b1, 12'h001, 32'h1, 32'h0, 1'b1);
        step();
        check("adc_res", alu_result_out, 32'h3);
        check("adc_nzcv", {28'h0, status_reg_out}, 32'h0);

        op(4'b0001, 1'b0, 12'h240, 32'h0, 32'h80000000, 1'b0);
        step();
        check("mov_asr4", alu_result_out, 32'hF8000000);

        op(4'b0001, 1'b0, 12'h260, 32'h0, 32'h80000000, 1'b0);
        step();
        check("mov_ror4", alu_result_out, 32'h08000000);
        check("ror_store", store_value_out, 32'h80000000);

        op(4'b0001, 1'b1, 12'h4FF, 32'h0, 32'h0, 1'b0);
        step();
        check("imm_rot8", alu_result_out, 32'hFF000000);

        op(4'b1001, 1'b1, 12'h4FF, 32'h0, 32'h0, 1'b0);
        step();
        check("mvn_imm", alu_result_out, 32'h00FFFFFF);

        op(4'b0010, 1'b0, 12'hFFF, 32'h00001000, 32'h0, 1'b0);
        mem_write_en_in = 1'b1;
        step();
        check("mem_offset", alu_result_out, 32'h00001FFF);
        check("mem_wr_ctrl", {29'h0, wb_enable_out, mem_read_en_out, mem_write_en_out}, 32'h5);

        op(4'b0010, 1'b1, 12'h001, 32'h20, 32'h0, 1'b0);
        fwd_sel_a = 2'b11; fwd_sel_b = 2'b10; wb_fwd_data = 32'h1234;
        step();
        check("fwd11_res", alu_result_out, 32'h21);
        check("fwd_wb_store", store_value_out, 32'h1234);

        op(4'b0010, 1'b1, 12'h001, 32'h99, 32'h0, 1'b1);
        fwd_sel_a = 2'b01; mem_fwd_data = 32'h10; dest_reg_in = 4'h7;
        step();
        check("fwd_mem_res", alu_result_out, 32'h11);
        check("fwd_mem_nzcv", {28'h0, status_reg_out}, 32'h0);

        freeze = 1'b1;
        op(4'b0100, 1'b1, 12'h005, 32'h5, 32'h0, 1'b1);
        mem_read_en_in = 1'b1; wb_enable_in = 1'b0; dest_reg_in = 4'hC;
        step(); step(); step();
        check("frz_res", alu_result_out, 32'h11);
        check("frz_nzcv", {28'h0, status_reg_out}, 32'h0);
        check("frz_dest", {28'h0, dest_reg_out}, 32'h7);
        check("frz_ctrl", {29'h0, wb_enable_out, mem_read_en_out, mem_write_en_out}, 32'h4);

        freeze = 1'b0;
        op(4'b0100, 1'b1, 12'h005, 32'h5, 32'h0, 1'b1);
        step();
        check("cmp2_nzcv", {28'h0, status_reg_out}, 32'h6);

        op(4'b1111, 1'b1, 12'h005, 32'h9, 32'h0, 1'b1);
        step();
        check("bad_op_res", alu_result_out, 32'h0);
        check("bad_op_nzcv", {28'h0, status_reg_out}, 32'h6);

        op(4'b0101, 1'b1, 12'h003, 32'hA, 32'h0, 1'b1);
        step();
        check("sbc_res", alu_result_out, 32'h7);
        check("sbc_nzcv", {28'h0, status_reg_out}, 32'h2);

        PC_in = 32'h100; signed_immediate_in = 24'hFFFFFE; branch_taken_in = 1'b1;
        #1;
        check("br_taken", {31'h0, branch_taken_out}, 32'h1);
        check("br_addr", branch_address_out, 32'h000000F8);
        branch_taken_in = 1'b0;
        #1;
        check("br_not_taken", {31'h0, branch_taken_out}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage_module.md
Name: ex_stage_module

Overview:
Execute stage plus EX/MEM pipeline register for the 5-stage ARM core. It consumes the registered ID/EX bundle and applies operand forwarding. It generates Val2 from the immediate or shifter operand, runs the ALU, and updates the NZCV status register that feeds back to the decode stage. It drives branch redirect to IF combinationally and registers results toward the MEM stage.

Parameters:
ADDRESS_LEN, 32, PC/address width (`define)
REGISTER_LEN, 32, datapath width (`define)
REG_ADDRESS_LEN, 4, register index width (`define)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
freeze  in  1  MEM-stage stall; hold EX/MEM register and status register
PC_in  in  32  PC+4 of the instruction in EX
execute_command_in  in  4  ALU opcode
mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in, branch_taken_in, status_write_enable_in  in  1 each  control
reg_file_in1, reg_file_in2  in  32  Rn, Rm values
dest_reg_in  in  4  Rd
signed_immediate_in  in  24  branch offset
shift_operand_in  in  12  shifter operand
fwd_sel_a, fwd_sel_b  in  2  00 reg file, 01 mem_fwd_data, 10 wb_fwd_data
mem_fwd_data, wb_fwd_data  in  32  forwarded values
branch_taken_out  out  1  combinational redirect to IF
branch_address_out  out  32  combinational target
status_reg_out  out  4  NZCV, registered
alu_result_out  out  32  registered
store_value_out  out  32  registered forwarded Rm
dest_reg_out  out  4  registered
wb_enable_out, mem_read_en_out, mem_write_en_out  out  1  registered

Behaviour:
- Reset: all registered outputs and status_reg_out are 0. rst has priority over freeze.
- Operand A: forwarding mux on reg_file_in1. Operand B raw: the same mux applied to reg_file_in2. fwd_sel 11 is treated as 00.
- Val2 when immediate_in=1: zero-extend shift_operand[7:0], then rotate right by 2*shift_operand[11:8].
- Val2 when mem_read_en_in or mem_write_en_in is set (and immediate_in=0): zero-extend shift_operand[11:0].
- Val2 otherwise: B shifted by shift_operand[11:7] positions; shift_operand[6:5] selects 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes B through.
- ALU opcode encoding (shared):
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: A+Val2
  - 0011 ADC: A+Val2+C
  - 0100 SUB/CMP: A-Val2
  - 0101 SBC: A-Val2-!C
  - 0110 AND/TST
  - 0111 ORR
  - 1000 EOR
  - Any other opcode gives result 0 and leaves flags unchanged.
- Flags: N=res[31]; Z=(res==0).
  - Arithmetic: 33-bit sum. C=bit32, where SUB is computed as A+~Val2+1, so C = not-borrow.
  - Arithmetic: V=signed overflow of the sum.
  - Logical and MOV/MVN: C and V are kept.
- Status register: loads {N,Z,C,V} on the clock edge when status_write_enable_in=1 and freeze=0. ADC/SBC use the current registered C.
- Branch: branch_taken_out = branch_taken_in (pure pass-through, zero latency).
- Branch target: branch_address_out = PC_in + {sign_ext(signed_immediate_in),2'b00}, modulo 2^32.
- EX/MEM register: 1-cycle latency. When freeze=0 it captures the ALU result, operand B as store_value_out, dest_reg_in, and the three control bits. When freeze=1 all registered outputs hold.
- No flush input: upstream flush already zeroes the control bits in ID/EX.
- Wrap-around: all adds are modulo 2^32; ROR by 0 is identity.

Decomposition:
- Opcode constants, shift-type codes and fwd_sel codes go in Defines.v next to the existing widths.
- One sub-module, val2_generator (combinational), holds the immediate/shift logic. It is unit-testable in isolation.
- ALU, status register and EX/MEM register stay in ex_stage_module.

Test Plan:
- rst=1 for 2 cycles with random inputs -> all registered outputs and status_reg_out are 0.
- ADD A=0x7FFFFFFF, imm 0x001 (rotate 0), S=1 -> alu_result_out=0x80000000 next cycle; status_reg_out=4'b1001 (N, V set).
- SUB/CMP A=5, Val2=5, status_write_enable=1 -> Z=1, C=1, N=0, V=0 (0110). Follow with ADC 1+1 -> result 3.
- Register operand B=0x80000000, shift_operand ASR #4 with MOV -> 0xF8000000. Same input with ROR #4 -> 0x08000000.
- fwd_sel_a=01, mem_fwd_data=0x10, reg_file_in1=0x99, ADD Val2=1 -> 0x11. Assert freeze for 3 cycles with new inputs -> outputs and flags frozen at 0x11 and prior NZCV.
- Branch with PC_in=0x100, signed_immediate=0xFFFFFE -> branch_taken_out=1 same cycle; branch_address_out=0xF8.
